// File: rtl/net_pkg.sv
// net_pkg: shared inference-datapath constants, layer indices and arbiter state type
package net_pkg;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int L1 = 0;
  localparam int L2 = 1;
  localparam int L3 = 2;
  localparam int N_IN = 784;
  localparam int N_HID = 128;
  localparam int N_OUT = 32;
  typedef enum logic {IDLE, OWNED} arb_state_t;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request scanning circularly from ptr
module rr_pick #(
  parameter int N = 3,
  parameter int PW = net_pkg::idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] pick,
  output logic          any
);
  logic [PW-1:0] idx;
  // scan from farthest to nearest so the nearest hit wins
  always_comb begin
    pick = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        pick = idx;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/weight_mem_arbiter.sv
// weight_mem_arbiter: round-robin burst-limited sharing of one read port with tagged responses
module weight_mem_arbiter #(
  parameter int N_REQ = 3,
  parameter int ADDR_W = net_pkg::ADDR_W,
  parameter int DATA_W = net_pkg::DATA_W,
  parameter int RD_LAT = 2,
  parameter int BURST_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy
);
  import net_pkg::*;
  localparam int PW = idx_w(N_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_t state, state_n;
  logic [PW-1:0] own, own_n, ptr, ptr_n, pick, nxt;
  logic [BW-1:0] bcnt, bcnt_n;
  logic any, own_ok, beat, last, others;
  logic [N_REQ-1:0] own_oh;
  logic [RD_LAT*N_REQ-1:0] tags;

  rr_pick #(.N(N_REQ)) u_pick (.req(req), .ptr(ptr), .pick(pick), .any(any));

  always_comb begin
    own_ok = 32'(own) < N_REQ;
    own_oh = (state == OWNED && own_ok) ? N_REQ'(1) << own : '0;
    beat = |(req & own_oh);
    others = |(req & ~own_oh);
    last = beat && bcnt == BW'(BURST_MAX - 1);
    nxt = own == PW'(N_REQ - 1) ? '0 : own + 1'b1;
    gnt = req & own_oh;
    mem_en = beat;
    mem_addr = beat ? addr[own*ADDR_W +: ADDR_W] : '0;
  end

  // a lone owner wraps its beat counter instead of releasing
  always_comb begin
    state_n = state;
    own_n = own;
    ptr_n = ptr;
    bcnt_n = bcnt;
    if (state == IDLE) begin
      if (any) begin
        state_n = OWNED;
        own_n = pick;
        bcnt_n = '0;
      end
    end else if (!own_ok) begin
      state_n = IDLE;
    end else if (!beat || (last && others)) begin
      state_n = IDLE;
      ptr_n = nxt;
      bcnt_n = '0;
    end else begin
      bcnt_n = last ? '0 : bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own <= '0;
      ptr <= '0;
      bcnt <= '0;
      tags <= '0;
    end else begin
      state <= state_n;
      own <= own_n;
      ptr <= ptr_n;
      bcnt <= bcnt_n;
      tags <= (RD_LAT*N_REQ)'({tags, gnt});
    end
  end

  assign rvalid = tags[RD_LAT*N_REQ-1 -: N_REQ];
  assign rdata = mem_rdata;
  assign busy = (state == OWNED) | (|tags);
endmodule

// File: tb/tb_weight_mem_arbiter.sv
// tb_weight_mem_arbiter: directed cycle-by-cycle check of grants, memory port and tagged responses
module tb_weight_mem_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req = '0;
  logic [3*AW-1:0] addr = '0;
  logic [2:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_rdata, m1, m2;
  logic mem_en, busy;
  logic [AW-1:0] mem_addr;
  int errors = 0;
  int checks = 0;
  int cy = 0;
  logic [2:0] ep0 = '0, ep1 = '0;
  logic [AW-1:0] ea0 = '0, ea1 = '0;

  weight_mem_arbiter #(.N_REQ(3), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    m1 <= f(mem_addr);
    m2 <= m1;
  end
  assign mem_rdata = m2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cy, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] r, input logic [2:0] eg, input logic eo);
    logic [AW-1:0] ea;
    @(posedge clk);
    #1;
    cy++;
    req = r;
    addr = {AW'(8192 + cy), AW'(4096 + cy), AW'(cy)};
    #1;
    ea = eg[0] ? AW'(cy) : eg[1] ? AW'(4096 + cy) : eg[2] ? AW'(8192 + cy) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("mem_en", 32'(mem_en), 32'(|eg));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("rvalid", 32'(rvalid), 32'(ep1));
    if (ep1 != 3'b000) chk("rdata", 32'(rdata), 32'(f(ea1)));
    chk("busy", 32'(busy), 32'(eo | (|ep0) | (|ep1)));
    ep1 = ep0;
    ep0 = eg;
    ea1 = ea0;
    ea0 = ea;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cy++;
    ep0 = '0;
    ep1 = '0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    do_reset();
    // single requester, four beats
    cyc(3'b001, 3'b000, 1'b0);
    repeat (4) cyc(3'b001, 3'b001, 1'b1);
    cyc(3'b000, 3'b000, 1'b1);
    cyc(3'b000, 3'b000, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    // full contention from reset: 0,1,2,0 with a gap between owners
    do_reset();
    for (int o = 0; o < 3; o++) begin
      cyc(3'b111, 3'b000, 1'b0);
      repeat (4) cyc(3'b111, 3'(1 << o), 1'b1);
    end
    cyc(3'b111, 3'b000, 1'b0);
    cyc(3'b111, 3'b001, 1'b1);
    cyc(3'b000, 3'b000, 1'b1);
    cyc(3'b000, 3'b000, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    // preemption: req[2] appears at beat 2 of owner 0
    cyc(3'b001, 3'b000, 1'b0);
    cyc(3'b001, 3'b001, 1'b1);
    cyc(3'b001, 3'b001, 1'b1);
    cyc(3'b101, 3'b001, 1'b1);
    cyc(3'b101, 3'b001, 1'b1);
    cyc(3'b101, 3'b000, 1'b0);
    cyc(3'b101, 3'b100, 1'b1);
    cyc(3'b000, 3'b000, 1'b1);
    cyc(3'b000, 3'b000, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    // lone requester keeps ownership past the burst limit
    cyc(3'b010, 3'b000, 1'b0);
    repeat (10) cyc(3'b010, 3'b010, 1'b1);
    cyc(3'b000, 3'b000, 1'b1);
    cyc(3'b000, 3'b000, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    // early drop with reads still in flight while requester 1 takes over
    cyc(3'b011, 3'b000, 1'b0);
    cyc(3'b011, 3'b001, 1'b1);
    cyc(3'b011, 3'b001, 1'b1);
    cyc(3'b010, 3'b000, 1'b1);
    cyc(3'b010, 3'b000, 1'b0);
    cyc(3'b010, 3'b010, 1'b1);
    cyc(3'b000, 3'b000, 1'b1);
    cyc(3'b000, 3'b000, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    // reset one cycle after a beat drops its response and clears ptr
    cyc(3'b001, 3'b000, 1'b0);
    cyc(3'b001, 3'b001, 1'b1);
    do_reset();
    cyc(3'b110, 3'b000, 1'b0);
    cyc(3'b110, 3'b010, 1'b1);
    cyc(3'b000, 3'b000, 1'b1);
    cyc(3'b000, 3'b000, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
